// File: rtl/latency_mem_pkg.sv
// Shared encodings for the latency memory model: FSM states, op codes, counter width.
package latency_mem_pkg;

  // Wide enough for LATENCY-1 with LATENCY up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/latency_mem_array.sv
// Single-ported word storage: synchronous write, combinational read of the same index.
module latency_mem_array #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_idx,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  // Contents survive reset; only the write strobe updates them
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/latency_mem.sv
// Bus-side memory controller with a fixed access latency for the multi-cycle CPU.
// Optional access counters are enabled by defining LATENCY_MEM_STATS_EN.
module latency_mem
  import latency_mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy,
  output logic                 err
`ifdef LATENCY_MEM_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] read_count,
  output logic [WORD_SIZE-1:0] write_count
`endif
);

  // WAIT runs LATENCY cycles: load LATENCY-1 and leave on zero
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t           r_state;
  mem_state_t           w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  mem_op_t              r_op;
  mem_op_t              w_op_next;
  logic [ADDR_W-1:0]    r_idx;
  logic [ADDR_W-1:0]    w_idx_next;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] w_wdata_next;
  logic                 w_err_next;
  logic                 w_ready_next;
  logic                 w_ack_next;
  logic                 w_we;
  logic [WORD_SIZE-1:0] w_rdata;
  logic                 w_addr_unused;

  // Upper address bits alias onto the low ADDR_W bits
  assign w_addr_unused = ^address[WORD_SIZE-1:ADDR_W];

  // Next-state, request latching and countdown
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_idx_next   = r_idx;
    w_wdata_next = r_wdata;
    w_err_next   = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (readM && writeM) begin
          w_err_next = 1'b1;
        end else if (readM) begin
          w_op_next    = MEM_OP_READ;
          w_idx_next   = address[ADDR_W-1:0];
          w_cnt_next   = CNT_LOAD;
          w_state_next = MEM_WAIT;
        end else if (writeM) begin
          w_op_next    = MEM_OP_WRITE;
          w_idx_next   = address[ADDR_W-1:0];
          w_wdata_next = data;
          w_cnt_next   = CNT_LOAD;
          w_state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = MEM_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      MEM_DONE: begin
        w_state_next = MEM_IDLE;
      end
      default: begin
        w_state_next = MEM_IDLE;
      end
    endcase
  end

  // Pulses are registered so they align exactly with the DONE cycle
  assign w_ready_next = (w_state_next == MEM_DONE) && (r_op == MEM_OP_READ);
  assign w_ack_next   = (w_state_next == MEM_DONE) && (r_op == MEM_OP_WRITE);

  // State register, request latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MEM_IDLE;
      r_cnt      <= '0;
      r_op       <= MEM_OP_READ;
      r_idx      <= '0;
      r_wdata    <= '0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_op       <= w_op_next;
      r_idx      <= w_idx_next;
      r_wdata    <= w_wdata_next;
      inputReady <= w_ready_next;
      ackOutput  <= w_ack_next;
      busy       <= (w_state_next != MEM_IDLE);
      err        <= w_err_next;
    end
  end

  // Commit happens on the edge that leaves DONE; reset in DONE cancels it
  assign w_we = (r_state == MEM_DONE) && (r_op == MEM_OP_WRITE) && !reset;

  latency_mem_array #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_idx  (r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  // Drive the shared bus only in a read DONE cycle, when the CPU is waiting
  assign data = inputReady ? w_rdata : {WORD_SIZE{1'bz}};

`ifdef LATENCY_MEM_STATS_EN
  // Saturating per-op completion counters, bumped on the edge leaving DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (r_state == MEM_DONE) begin
      if (r_op == MEM_OP_READ) begin
        if (read_count != '1) begin
          read_count <= read_count + WORD_SIZE'(1);
        end
      end else begin
        if (write_count != '1) begin
          write_count <= write_count + WORD_SIZE'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_latency_mem.sv
// Directed bench: instance A (LATENCY=2) for access/err/reset/alias, instance B (LATENCY=3) for streaming.
module tb_latency_mem;

  localparam int unsigned WS = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned LA = 2;
  localparam int unsigned LB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          a_read, a_write, a_oe;
  logic [WS-1:0] a_addr, a_drv;
  wire  [WS-1:0] a_data;
  logic          a_rdy, a_ack, a_busy, a_err;
  assign a_data = a_oe ? a_drv : {WS{1'bz}};

  logic          b_read, b_write, b_oe;
  logic [WS-1:0] b_addr, b_drv;
  wire  [WS-1:0] b_data;
  logic          b_rdy, b_ack, b_busy, b_err;
  assign b_data = b_oe ? b_drv : {WS{1'bz}};

`ifdef LATENCY_MEM_STATS_EN
  logic [WS-1:0] a_rc, a_wc, b_rc, b_wc;
`endif

  int total = 0;
  int bad   = 0;

  latency_mem #(.WORD_SIZE(WS), .ADDR_W(AW), .LATENCY(LA)) u_a (
    .clk(clk), .reset(reset), .readM(a_read), .writeM(a_write), .address(a_addr),
    .data(a_data), .inputReady(a_rdy), .ackOutput(a_ack), .busy(a_busy), .err(a_err)
`ifdef LATENCY_MEM_STATS_EN
    , .read_count(a_rc), .write_count(a_wc)
`endif
  );

  latency_mem #(.WORD_SIZE(WS), .ADDR_W(AW), .LATENCY(LB)) u_b (
    .clk(clk), .reset(reset), .readM(b_read), .writeM(b_write), .address(b_addr),
    .data(b_data), .inputReady(b_rdy), .ackOutput(b_ack), .busy(b_busy), .err(b_err)
`ifdef LATENCY_MEM_STATS_EN
    , .read_count(b_rc), .write_count(b_wc)
`endif
  );

  // One access on instance A; records when pulses land (cycles after the sampling edge)
  task automatic a_access(input logic wr, input logic [WS-1:0] addr, input logic [WS-1:0] wd,
                          output logic [WS-1:0] rd, output int ack_at, output int rdy_at,
                          output int pulses, output int busy_n, output logic bus_ok);
    rd = '0; ack_at = -1; rdy_at = -1; pulses = 0; busy_n = 0; bus_ok = 1'b1;
    @(negedge clk);
    a_addr = addr; a_read = ~wr; a_write = wr; a_drv = wr ? wd : '0; a_oe = 1'b1;
    for (int n = 1; n <= int'(LA) + 3; n++) begin
      @(negedge clk);
      if (a_oe && (a_data !== a_drv)) bus_ok = 1'b0;
      if (a_rdy && rdy_at < 0) begin rdy_at = n; rd = a_data; end
      if (a_ack && ack_at < 0) ack_at = n;
      pulses = pulses + int'(a_rdy) + int'(a_ack) + int'(a_err);
      if (a_busy) busy_n++;
      if (n == 1) begin a_read = 1'b0; a_write = 1'b0; a_drv = '0; end
      if (n == int'(LA) && !wr) a_oe = 1'b0;
      if (n == int'(LA) + 2) a_oe = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_read = 0; a_write = 0; a_addr = '0; a_drv = '0; a_oe = 1'b1;
    b_read = 0; b_write = 0; b_addr = '0; b_drv = '0; b_oe = 1'b0;
    @(negedge clk);
    total++;
    if ({a_rdy, a_ack, a_busy, a_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs_a: got %b expected 0000", {a_rdy, a_ack, a_busy, a_err});
    end
    total++;
    if ({b_rdy, b_ack, b_busy, b_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs_b: got %b expected 0000", {b_rdy, b_ack, b_busy, b_err});
    end
    total++;
    if (a_data !== 16'h0000) begin
      bad++; $display("FAIL reset_bus: got %h expected 0000", a_data);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({a_rdy, a_ack, a_busy, a_err} !== 4'b0000) begin
      bad++; $display("FAIL post_reset_idle: got %b expected 0000", {a_rdy, a_ack, a_busy, a_err});
    end
  endtask

  task automatic test_write_read();
    logic [WS-1:0] rd; int ack_at, rdy_at, pulses, busy_n; logic bus_ok;
    a_access(1'b1, 16'h0010, 16'hBEEF, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (ack_at != int'(LA) + 1) begin bad++; $display("FAIL wr_ack_cycle: got %0d expected %0d", ack_at, LA + 1); end
    total++;
    if (rdy_at != -1 || pulses != 1) begin
      bad++; $display("FAIL wr_pulses: got rdy_at=%0d pulses=%0d expected -1/1", rdy_at, pulses);
    end
    total++;
    if (busy_n != int'(LA) + 1) begin bad++; $display("FAIL wr_busy: got %0d expected %0d", busy_n, LA + 1); end
    total++;
    if (bus_ok !== 1'b1) begin bad++; $display("FAIL wr_bus_free: got %b expected 1", bus_ok); end
    a_access(1'b0, 16'h0010, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (rdy_at != int'(LA) + 1) begin bad++; $display("FAIL rd_ready_cycle: got %0d expected %0d", rdy_at, LA + 1); end
    total++;
    if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h expected beef", rd); end
    total++;
    if (ack_at != -1 || pulses != 1) begin
      bad++; $display("FAIL rd_pulses: got ack_at=%0d pulses=%0d expected -1/1", ack_at, pulses);
    end
    total++;
    if (bus_ok !== 1'b1) begin bad++; $display("FAIL rd_bus_free: got %b expected 1", bus_ok); end
  endtask

  task automatic test_error();
    logic [WS-1:0] rd; int ack_at, rdy_at, pulses, busy_n; logic bus_ok;
    @(negedge clk);
    a_addr = 16'h0010; a_read = 1'b1; a_write = 1'b1; a_drv = 16'h1111; a_oe = 1'b1;
    @(negedge clk);
    total++;
    if ({a_err, a_busy, a_rdy, a_ack} !== 4'b1000) begin
      bad++; $display("FAIL err_pulse: got %b expected 1000", {a_err, a_busy, a_rdy, a_ack});
    end
    a_read = 1'b0; a_write = 1'b0; a_drv = '0;
    @(negedge clk);
    total++;
    if ({a_err, a_busy, a_rdy, a_ack} !== 4'b0000) begin
      bad++; $display("FAIL err_clear: got %b expected 0000", {a_err, a_busy, a_rdy, a_ack});
    end
    a_access(1'b0, 16'h0010, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (rd !== 16'hBEEF) begin bad++; $display("FAIL err_mem_kept: got %h expected beef", rd); end
  endtask

  task automatic test_alias();
    logic [WS-1:0] rd; int ack_at, rdy_at, pulses, busy_n; logic bus_ok;
    a_access(1'b1, 16'h0105, 16'hA5A5, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    a_access(1'b0, 16'h0005, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (rd !== 16'hA5A5) begin bad++; $display("FAIL alias_data: got %h expected a5a5", rd); end
    total++;
    if (rdy_at != int'(LA) + 1) begin bad++; $display("FAIL alias_ready: got %0d expected %0d", rdy_at, LA + 1); end
  endtask

  task automatic test_reset_abort();
    logic [WS-1:0] rd; int ack_at, rdy_at, pulses, busy_n; logic bus_ok;
    a_access(1'b1, 16'h0020, 16'h4321, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    @(negedge clk);
    a_addr = 16'h0020; a_write = 1'b1; a_drv = 16'h1234; a_oe = 1'b1;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL abort_in_wait: got busy=%b expected 1", a_busy); end
    a_write = 1'b0; a_drv = '0;
    reset = 1'b1;
    #1;
    total++;
    if ({a_rdy, a_ack, a_busy, a_err} !== 4'b0000) begin
      bad++; $display("FAIL abort_outs_now: got %b expected 0000", {a_rdy, a_ack, a_busy, a_err});
    end
    for (int n = 0; n < int'(LA) + 1; n++) begin
      @(negedge clk);
      total++;
      if ({a_rdy, a_ack, a_busy, a_err} !== 4'b0000 || a_data !== 16'h0000) begin
        bad++; $display("FAIL abort_hold_%0d: got outs=%b bus=%h expected 0000/0000", n,
                        {a_rdy, a_ack, a_busy, a_err}, a_data);
      end
    end
    reset = 1'b0;
    a_access(1'b0, 16'h0020, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (rd !== 16'h4321) begin bad++; $display("FAIL abort_no_commit: got %h expected 4321", rd); end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    @(negedge clk);
    b_addr = 16'h0003; b_write = 1'b1; b_drv = 16'h1357; b_oe = 1'b1;
    for (int n = 1; n <= int'(LB) + 3; n++) begin
      @(negedge clk);
      if (b_ack) acks++;
      if (n == 1) b_write = 1'b0;
    end
    b_oe = 1'b0;
    total++;
    if (acks != 1) begin bad++; $display("FAIL b_write_ack: got %0d expected 1", acks); end
    b_read = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      total++;
      if ({b_rdy, b_busy} !== {(n % 5) == 4, (n % 5) != 0}) begin
        bad++; $display("FAIL stream_c%0d: got rdy/busy=%b%b expected %b%b", n, b_rdy, b_busy,
                        (n % 5) == 4, (n % 5) != 0);
      end
      if ((n % 5) == 4) begin
        total++;
        if (b_data !== 16'h1357) begin bad++; $display("FAIL stream_data_c%0d: got %h expected 1357", n, b_data); end
      end
    end
    b_read = 1'b0;
    repeat (int'(LB) + 3) @(negedge clk);
    total++;
    if ({b_rdy, b_busy} !== 2'b00) begin bad++; $display("FAIL stream_stop: got %b%b expected 00", b_rdy, b_busy); end
  endtask

`ifdef LATENCY_MEM_STATS_EN
  task automatic test_stats();
    logic [WS-1:0] rd; int ack_at, rdy_at, pulses, busy_n; logic bus_ok;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total++;
    if (a_rc !== 16'd0 || a_wc !== 16'd0) begin
      bad++; $display("FAIL stats_reset0: got %0d/%0d expected 0/0", a_rc, a_wc);
    end
    a_access(1'b1, 16'h0030, 16'h0001, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    a_access(1'b0, 16'h0030, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    @(negedge clk);
    a_read = 1'b1; a_write = 1'b1;
    @(negedge clk);
    a_read = 1'b0; a_write = 1'b0;
    a_access(1'b1, 16'h0031, 16'h0002, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    a_access(1'b0, 16'h0031, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    a_access(1'b0, 16'h0010, '0, rd, ack_at, rdy_at, pulses, busy_n, bus_ok);
    total++;
    if (a_rc !== 16'd3) begin bad++; $display("FAIL stats_reads: got %0d expected 3", a_rc); end
    total++;
    if (a_wc !== 16'd2) begin bad++; $display("FAIL stats_writes: got %0d expected 2", a_wc); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    total++;
    if (a_rc !== 16'd0 || a_wc !== 16'd0) begin
      bad++; $display("FAIL stats_reset1: got %0d/%0d expected 0/0", a_rc, a_wc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_alias();
    test_reset_abort();
    test_back_to_back();
`ifdef LATENCY_MEM_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
